// File: rtl/if_id_stage_if.sv
// Fetch/decode boundary bundle: fetch-side handshake in, decode-side fields out.
interface if_id_stage_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned IMM_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [OP_W-1:0]    out_opcode;
    logic [REG_W-1:0]   out_rd;
    logic [REG_W-1:0]   out_rs1;
    logic [REG_W-1:0]   out_rs2;
    logic [IMM_W-1:0]   out_imm;
    logic [15:0]        stall_cnt;

    // Environment side: drives fetch inputs and decode ready.
    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_imm, stall_cnt
    );

    // Stage side.
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_imm, stall_cnt
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID boundary: two-entry skid buffer (main + skid) with field split,
// synchronous flush and a saturating back-pressure counter.
module if_id_stage #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned IMM_W   = 16
) (
    input logic          clk,
    input logic          rst,
    if_id_stage_if.slave bus
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [15:0]        stall_q, stall_d;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic pop;

    // Handshake flags depend on the state register only.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign accept    = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    // Next-state and entry movement; flush overrides any accept or pop.
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (bus.flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d      = StOne;
                        main_instr_d = bus.in_instr;
                        main_pc_d    = bus.in_pc;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_instr_d = bus.in_instr;
                        main_pc_d    = bus.in_pc;
                    end else if (accept) begin
                        state_d      = StFull;
                        skid_instr_d = bus.in_instr;
                        skid_pc_d    = bus.in_pc;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_d      = StOne;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Stall counter saturates rather than wrapping; flush does not touch it.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !bus.out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // State, entries and counter; async reset empties the buffer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StEmpty;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            stall_q      <= stall_d;
        end
    end

    // Decode fields come from the main entry only.
    always_comb begin
        bus.in_ready   = in_ready;
        bus.out_valid  = out_valid;
        bus.out_pc     = main_pc_q;
        bus.out_opcode = main_instr_q[INSTR_W-1 -: OP_W];
        bus.out_rd     = main_instr_q[INSTR_W-OP_W-1 -: REG_W];
        bus.out_rs1    = main_instr_q[INSTR_W-OP_W-REG_W-1 -: REG_W];
        bus.out_rs2    = main_instr_q[INSTR_W-OP_W-2*REG_W-1 -: REG_W];
        bus.out_imm    = main_instr_q[IMM_W-1:0];
        bus.stall_cnt  = stall_q;
    end

endmodule
